// File: rtl/mips_pkg.sv
// Shared MIPS constants: the opcodes the main decoder recognises, the
// loader's instruction-class encodings and the encoder state enumeration.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    KIND_R   = 2'b00,
    KIND_LW  = 2'b01,
    KIND_SW  = 2'b10,
    KIND_BEQ = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_FULL  = 2'b11
  } enc_state_e;

endpackage

// File: rtl/mips_instr_encoder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flush empties it and overrides
// any push or pop presented in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_s;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign occ_s  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign single = (occ_s == (AW+1)'(1));
  assign dout   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes instruction descriptors into MIPS words, buffers
// them and writes them to instruction memory at auto-incrementing addresses.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  function automatic logic [31:0] encode_instr(
    input logic [1:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm
  );
    logic [31:0] word;
    case (kind_e'(kind))
      KIND_R:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_LW: word = {OP_LW, rs, rt, imm};
      KIND_SW: word = {OP_SW, rs, rt, imm};
      default: word = {OP_BEQ, rs, rt, imm};
    endcase
    return word;
  endfunction

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  logic              fifo_full_s, fifo_empty_s, fifo_single_s;
  logic [31:0]       fifo_dout_s;
  logic              push_s, pop_s, flush_s, active_s;

  assign active_s = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign in_ready = (state_q == ST_LOAD) && !fifo_full_s;
  assign im_we    = active_s && !fifo_empty_s;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = im_we && im_ready;

  assign im_addr  = addr_q;
  assign im_wdata = fifo_dout_s;
  assign count    = count_q;
  assign busy     = active_s;
  assign done     = done_q;
  assign overflow = overflow_q;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .push   (push_s),
    .pop    (pop_s),
    .flush  (flush_s),
    .din    (encode_instr(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm)),
    .dout   (fifo_dout_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .single (fifo_single_s)
  );

  // Session control; start outranks everything, address wrap outranks done/finish.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    flush_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_FULL: begin
        if (start) begin
          state_d    = ST_LOAD;
          addr_d     = base_addr;
          count_d    = '0;
          overflow_d = 1'b0;
          flush_s    = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD, ST_DRAIN: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = base_addr;
          count_d = '0;
          flush_s = 1'b1;
        end else if (pop_s) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W+1)'(1);
          if (addr_q == '1) begin
            state_d    = ST_FULL;
            overflow_d = 1'b1;
            flush_s    = 1'b1;
          end else if ((state_q == ST_DRAIN) && fifo_single_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if ((state_q == ST_LOAD) && finish) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = state_q;
          end
        end else if ((state_q == ST_DRAIN) && fifo_empty_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if ((state_q == ST_LOAD) && finish) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed scenarios plus random
// sessions, checked against an arithmetic encoding model.
module tb_mips_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, start, finish;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid, in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic              im_we, im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   count;
  logic              busy, done, overflow;

  logic rand_ready = 1'b0;
  logic rand_bit   = 1'b1;
  logic ready_force;

  always #5 clk = ~clk;
  assign im_ready = rand_ready ? rand_bit : ready_force;
  always @(posedge clk) begin
    #1 rand_bit = 1'($urandom_range(0, 1));
  end

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .busy(busy), .done(done), .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0]       exp_q [$];
  logic [ADDR_W-1:0] model_addr = '0;
  int writes = 0;
  int cyc = 0;
  int last_write_cyc = -10;
  logic              prev_stall = 1'b0;
  logic [31:0]       prev_data = '0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoding: opcode and fields placed by weight.
  function automatic logic [31:0] model_word(input int kind, input int rs, input int rt,
                                             input int rd, input int funct, input int imm);
    longint op, w;
    case (kind)
      0: op = 0;
      1: op = 35;
      2: op = 43;
      default: op = 4;
    endcase
    w = op * 64'd67108864 + longint'(rs) * 64'd2097152 + longint'(rt) * 64'd65536;
    if (kind == 0) w = w + longint'(rd) * 64'd2048 + longint'(funct);
    else           w = w + longint'(imm);
    return w[31:0];
  endfunction

  // Monitor: every completed write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    cyc++;
    if (prev_stall && im_we) begin
      check("hold_addr", 64'(im_addr), 64'(prev_addr));
      check("hold_data", 64'(im_wdata), 64'(prev_data));
    end
    prev_stall = im_we && !im_ready;
    prev_addr  = im_addr;
    prev_data  = im_wdata;
    if (im_we && im_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h at %0d expected no write", im_wdata, im_addr);
      end else begin
        check("wr_data", 64'(im_wdata), 64'(exp_q.pop_front()));
        check("wr_addr", 64'(im_addr), 64'(model_addr));
      end
      model_addr = model_addr + 1'b1;
      writes++;
      last_write_cyc = cyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic try_push(input int kind, input int rs, input int rt, input int rd,
                          input int funct, input int imm, input logic [31:0] expw,
                          input int budget, output bit acc);
    in_kind = 2'(kind); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_funct = 6'(funct); in_imm = 16'(imm);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk); #1;
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(expw);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_fixed(input int kind, input int rs, input int rt, input int rd,
                            input int funct, input int imm, input logic [31:0] expw);
    bit acc;
    try_push(kind, rs, rt, rd, funct, imm, expw, 20, acc);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept");
    end
  endtask

  task automatic push_rand(input int budget, output bit acc);
    int k, rs, rt, rd, fn, im;
    k = $urandom_range(0, 3); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
    rd = $urandom_range(0, 31); fn = $urandom_range(0, 63); im = $urandom_range(0, 65535);
    try_push(k, rs, rt, rd, fn, im, model_word(k, rs, rt, rd, fn, im), budget, acc);
  endtask

  task automatic do_start(input int b);
    base_addr = ADDR_W'(b);
    model_addr = ADDR_W'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done) begin seen = 1'b1; dcyc = cyc; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done pulse expected one within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_im_we"},    64'(im_we),    64'(0));
    check({tag, "_im_addr"},  64'(im_addr),  64'(0));
    check({tag, "_im_wdata"}, 64'(im_wdata), 64'(0));
    check({tag, "_count"},    64'(count),    64'(0));
    check({tag, "_busy"},     64'(busy),     64'(0));
    check({tag, "_done"},     64'(done),     64'(0));
    check({tag, "_overflow"}, 64'(overflow), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int dcyc, w0, n, dseen;
    reset = 1'b1; start = 1'b0; finish = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
    ready_force = 1'b1;
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(1);

    // R-type and I-type encodes at consecutive addresses from 0
    do_start(0);
    push_fixed(0, 1, 2, 3, 'h20, 0, 32'h00221820);
    cycles(3);
    check("rtype_count", 64'(count), 64'(1));
    push_fixed(1, 0, 8, 0, 0, 'h0004, 32'h8C080004);
    push_fixed(2, 0, 8, 0, 0, 'h0008, 32'hAC080008);
    push_fixed(3, 8, 9, 0, 0, 'hFFFF, 32'h1109FFFF);
    cycles(3);
    check("itype_count", 64'(count), 64'(4));
    check("itype_addr", 64'(im_addr), 64'(4));

    // Backpressure: FIFO fills after DEPTH accepts
    ready_force = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_rand(5, acc);
      check("bp_accept", 64'(acc), 64'(1));
    end
    push_rand(3, acc);
    check("bp_blocked", 64'(acc), 64'(0));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_im_we", 64'(im_we), 64'(1));
    ready_force = 1'b1;
    push_rand(10, acc);
    check("bp_fifth", 64'(acc), 64'(1));
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Drain with three queued entries, then done pulse
    ready_force = 1'b0;
    for (int i = 0; i < 3; i++) push_rand(5, acc);
    w0 = writes;
    do_finish();
    check("drain_busy", 64'(busy), 64'(1));
    ready_force = 1'b1;
    wait_done(20, dcyc);
    check("drain_writes", 64'(writes - w0), 64'(3));
    check("done_after_last_pop", 64'(dcyc), 64'(last_write_cyc + 1));
    check("drain_count", 64'(count), 64'(12));
    check("drain_busy_off", 64'(busy), 64'(0));
    check("done_one_cycle", 64'(done), 64'(0));

    // Random sessions with random im_ready
    rand_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      do_start($urandom_range(0, 40));
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        push_rand(50, acc);
        if (!acc) begin checks++; errors++; $display("FAIL rand_accept: got no accept expected accept"); end
        cycles($urandom_range(0, 2));
      end
      do_finish();
      wait_done(200, dcyc);
      check("rand_count", 64'(count), 64'(n));
      check("rand_busy", 64'(busy), 64'(0));
      check("rand_sb_empty", 64'(exp_q.size()), 64'(0));
    end
    rand_ready = 1'b0;

    // Overflow at the top of the address space
    ready_force = 1'b0;
    do_start(62);
    for (int i = 0; i < 4; i++) push_rand(5, acc);
    ready_force = 1'b1;
    dseen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (done) dseen++;
      @(posedge clk); #1;
    end
    check("ovf_flag", 64'(overflow), 64'(1));
    check("ovf_count", 64'(count), 64'(2));
    check("ovf_busy", 64'(busy), 64'(0));
    check("ovf_im_we", 64'(im_we), 64'(0));
    check("ovf_in_ready", 64'(in_ready), 64'(0));
    check("ovf_dropped", 64'(exp_q.size()), 64'(2));
    check("ovf_no_done", 64'(dseen), 64'(0));
    exp_q.delete();
    do_finish();
    cycles(2);
    check("ovf_finish_ignored", 64'(overflow), 64'(1));

    // Asynchronous reset mid-DRAIN, then restart at 10
    do_start(5);
    ready_force = 1'b0;
    for (int i = 0; i < 3; i++) push_rand(5, acc);
    do_finish();
    check("rst_pre_busy", 64'(busy), 64'(1));
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("arst");
    exp_q.delete();
    cycles(1);
    reset = 1'b0;
    ready_force = 1'b1;
    do_start(10);
    push_rand(5, acc);
    cycles(3);
    check("post_rst_count", 64'(count), 64'(1));
    check("post_rst_addr", 64'(im_addr), 64'(11));
    check("post_rst_sb", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Program-loader block for the single-cycle MIPS core. It accepts instruction descriptions (class plus register, funct and immediate fields) over a valid/ready handshake. It encodes each one into a 32-bit MIPS word using the opcodes the main decoder recognises: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04. Encoded words are buffered in a small FIFO and written sequentially into instruction memory through a stallable write port, with an auto-incrementing word address.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; loads base_addr and begins a load session.
- finish  in  1  one-cycle pulse; ends the session after the FIFO drains.
- base_addr  in  ADDR_W  first word address of the session.
- in_valid  in  1  instruction descriptor valid.
- in_ready  out  1  block can accept a descriptor this cycle.
- in_kind  in  2  instruction class: 00 R-type, 01 lw, 10 sw, 11 beq.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-type funct field.
- in_imm  in  16  immediate or branch offset.
- im_we  out  1  instruction-memory write request.
- im_ready  in  1  memory accepts the write this cycle.
- im_addr  out  ADDR_W  write word address.
- im_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written in the current session.
- busy  out  1  state is LOAD or DRAIN.
- done  out  1  one-cycle pulse when a session completes normally.
- overflow  out  1  sticky; address space exhausted.

## Operation
- Encoding, computed at accept time and stored already encoded:
  - R-type: {6'h00, rs, rt, rd, 5'b0, funct}.
  - lw: {6'h23, rs, rt, imm}.
  - sw: {6'h2B, rs, rt, imm}.
  - beq: {6'h04, rs, rt, imm}.
  - Fields not used by a class (rd and funct for I-type, imm for R-type) are ignored.
- Handshake:
  - A descriptor is accepted on a cycle with in_valid && in_ready.
  - in_ready = (state==LOAD) && !fifo_full. There is no same-cycle pass-through, so a full FIFO blocks input even if a pop happens that cycle.
- Write port:
  - im_we = (state is LOAD or DRAIN) && !fifo_empty.
  - im_wdata and im_addr are held stable while im_we && !im_ready.
  - On im_we && im_ready: pop the FIFO, increment im_addr (wraps modulo 2^ADDR_W), increment count.
- State machine:
  - IDLE: in_ready=0, im_we=0. On start, load im_addr=base_addr, clear count, clear overflow, go to LOAD.
  - LOAD: accept descriptors and write them. On finish, go to DRAIN; a descriptor accepted in the same cycle as finish is kept.
  - DRAIN: in_ready=0. When the FIFO is empty, pulse done for one cycle and go to IDLE.
  - FULL: entered on a completed write at im_addr == 2^ADDR_W-1, from LOAD or DRAIN. On entry the FIFO is flushed and overflow is set. In FULL, in_ready=0 and im_we=0; the block leaves FULL only on start or reset. done is not pulsed.
- start while in LOAD or DRAIN: flush the FIFO, reload im_addr=base_addr, clear count, stay in or return to LOAD. start has priority over finish.
- finish in IDLE or FULL is ignored.
- Simultaneous push and pop on a non-full FIFO: both take effect and the occupancy is unchanged.

## Timing
- Reset values: state=IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, count=0, busy=0, done=0, overflow=0, FIFO empty.
- Latency: a descriptor accepted in cycle N can produce im_we=1 no earlier than cycle N+1. With im_ready held at 1, sustained throughput is one word per cycle.
- done is asserted in the cycle after the last pop of the DRAIN state.
- Reset asserted mid-session clears all state immediately, including FIFO contents, with no write completing that cycle.

## Structure
- Shared package mips_pkg holds:
  - the opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04;
  - the in_kind encodings;
  - the state enumeration for this block.
- The main decoder also uses the opcode constants from mips_pkg.
- One sub-module: sync_fifo (parameter WIDTH=32, DEPTH). It has push/pop/flush inputs and full/empty outputs, with pointers one bit wider than log2(DEPTH).
- The encoder logic is a combinational function inside mips_instr_encoder.

## Test plan
- R-type encode: start with base_addr=0, then push kind=00, rs=1, rt=2, rd=3, funct=0x20. Required: im_wdata=0x00221820 at im_addr=0; count becomes 1.
- I-type encodes: push lw rs=0, rt=8, imm=0x0004, then sw rs=0, rt=8, imm=0x0008, then beq rs=8, rt=9, imm=0xFFFF. Required: 0x8C080004, 0xAC080008, 0x1109FFFF at consecutive addresses.
- Backpressure: hold im_ready=0 and push 5 descriptors. Required: in_ready drops after 4 accepts, and im_addr/im_wdata stay stable. Then release im_ready: 4 writes in order, then the 5th descriptor is accepted.
- Drain and done: pulse finish with 3 entries queued. Required: 3 more writes, then a one-cycle done pulse, then IDLE with busy=0.
- Overflow: ADDR_W=6, base_addr=62, push 4 descriptors. Required: writes at 62 and 63, then FULL with overflow=1, FIFO flushed, 2 words dropped, count=2.
- Asynchronous reset mid-DRAIN: assert reset between clock edges. Required: all outputs at their reset values immediately; a following start at base_addr=10 begins writing at address 10.
